// File: rtl/axil_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axil_master_bridge
// Purpose  : Turns the CPU's single-outstanding valid/ready load/store port
//            into AXI4-Lite master transactions. Only one transaction is in
//            flight at a time. Each request returns exactly one response:
//            read data or a write acknowledge, plus an error flag taken
//            from RRESP/BRESP bit 1 (SLVERR/DECERR).
// Ports    : aclk, aresetn        clock, asynchronous active-low reset
//            req_*                CPU request (valid/ready, we, addr, wdata,
//                                 wstrb)
//            rsp_*                CPU response (valid/ready, rdata, err)
//            M_AXI_aw*/w*/b*      AXI4-Lite write address/data/response
//            M_AXI_ar*/r*         AXI4-Lite read address/data
// Revision : 1.0  initial release
// ============================================================================
module axil_master_bridge #(
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  // CPU request port
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb,
  // CPU response port
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                        rsp_err,
  // AXI4-Lite write address channel
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic [2:0]                  M_AXI_awprot,
  output logic                        M_AXI_awvalid,
  input  logic                        M_AXI_awready,
  // AXI4-Lite write data channel
  output logic [AXI_DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                        M_AXI_wvalid,
  input  logic                        M_AXI_wready,
  // AXI4-Lite write response channel
  input  logic [1:0]                  M_AXI_bresp,
  input  logic                        M_AXI_bvalid,
  output logic                        M_AXI_bready,
  // AXI4-Lite read address channel
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_araddr,
  output logic [2:0]                  M_AXI_arprot,
  output logic                        M_AXI_arvalid,
  input  logic                        M_AXI_arready,
  // AXI4-Lite read data channel
  input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_rdata,
  input  logic [1:0]                  M_AXI_rresp,
  input  logic                        M_AXI_rvalid,
  output logic                        M_AXI_rready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t                      r_state;
  logic [AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] r_wstrb;

  // A write channel counts as done once its valid has already dropped or
  // its handshake completes this cycle; this covers AW-first, W-first and
  // same-cycle acceptance with one expression.
  logic w_aw_done;
  logic w_w_done;
  assign w_aw_done = !M_AXI_awvalid || M_AXI_awready;
  assign w_w_done  = !M_AXI_wvalid  || M_AXI_wready;

  // Only bit 1 of the response (SLVERR/DECERR) is meaningful to the CPU.
  logic w_unused_resp;
  assign w_unused_resp = M_AXI_bresp[0] ^ M_AXI_rresp[0];

  // The latched request drives the AXI address/data directly, so they stay
  // stable for as long as the corresponding valid is high.
  assign M_AXI_awaddr = r_addr;
  assign M_AXI_araddr = r_addr;
  assign M_AXI_wdata  = r_wdata;
  assign M_AXI_wstrb  = r_wstrb;
  assign M_AXI_awprot = 3'b000;
  assign M_AXI_arprot = 3'b000;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      M_AXI_awvalid <= 1'b0;
      M_AXI_wvalid  <= 1'b0;
      M_AXI_bready  <= 1'b0;
      M_AXI_arvalid <= 1'b0;
      M_AXI_rready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_wstrb   <= req_wstrb;
            req_ready <= 1'b0;
            if (req_we) begin
              M_AXI_awvalid <= 1'b1;
              M_AXI_wvalid  <= 1'b1;
              r_state       <= S_WR;
            end else begin
              M_AXI_arvalid <= 1'b1;
              r_state       <= S_RADDR;
            end
          end
        end

        S_WR: begin
          // Each valid drops independently after its own handshake.
          if (M_AXI_awvalid && M_AXI_awready) M_AXI_awvalid <= 1'b0;
          if (M_AXI_wvalid && M_AXI_wready)   M_AXI_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            M_AXI_bready <= 1'b1;
            r_state      <= S_WRESP;
          end
        end

        S_WRESP: begin
          if (M_AXI_bvalid) begin
            M_AXI_bready <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= M_AXI_bresp[1];
            rsp_valid    <= 1'b1;
            r_state      <= S_RESP;
          end
        end

        S_RADDR: begin
          if (M_AXI_arready) begin
            M_AXI_arvalid <= 1'b0;
            M_AXI_rready  <= 1'b1;
            r_state       <= S_RDATA;
          end
        end

        S_RDATA: begin
          if (M_AXI_rvalid) begin
            M_AXI_rready <= 1'b0;
            rsp_rdata    <= M_AXI_rdata;
            rsp_err      <= M_AXI_rresp[1];
            rsp_valid    <= 1'b1;
            r_state      <= S_RESP;
          end
        end

        S_RESP: begin
          // req_ready returns only after the response is taken, so the two
          // are never high together.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        default: begin
          r_state       <= S_IDLE;
          req_ready     <= 1'b1;
          rsp_valid     <= 1'b0;
          M_AXI_awvalid <= 1'b0;
          M_AXI_wvalid  <= 1'b0;
          M_AXI_bready  <= 1'b0;
          M_AXI_arvalid <= 1'b0;
          M_AXI_rready  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_master_bridge
// Purpose  : Self-checking bench for axil_master_bridge. A behavioural
//            AXI4-Lite slave with CLINT-like registers (msip at 0x0000,
//            mtimecmp at 0x4000, free-running mtime at 0xBFF8) and
//            programmable per-channel ready latencies answers the bridge.
// Revision : 1.0  initial release
// ============================================================================
module tb_axil_master_bridge;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] M_AXI_awaddr, M_AXI_araddr;
  logic [2:0]    M_AXI_awprot, M_AXI_arprot;
  logic          M_AXI_awvalid, M_AXI_awready, M_AXI_wvalid, M_AXI_wready;
  logic [DW-1:0] M_AXI_wdata, M_AXI_rdata;
  logic [3:0]    M_AXI_wstrb;
  logic [1:0]    M_AXI_bresp, M_AXI_rresp;
  logic          M_AXI_bvalid, M_AXI_bready, M_AXI_arvalid, M_AXI_arready;
  logic          M_AXI_rvalid, M_AXI_rready;

  always #5 aclk = ~aclk;

  axil_master_bridge #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awprot(M_AXI_awprot),
    .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready),
    .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb),
    .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready),
    .M_AXI_bresp(M_AXI_bresp), .M_AXI_bvalid(M_AXI_bvalid),
    .M_AXI_bready(M_AXI_bready),
    .M_AXI_araddr(M_AXI_araddr), .M_AXI_arprot(M_AXI_arprot),
    .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
    .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp),
    .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready)
  );

  // ---------------------------------------------------------------- checking
  int n_vec = 0;
  int n_fail = 0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    bit            chk_data;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event, required one", name);
  endtask

  // Compares the response currently on the port with the oldest expectation.
  task automatic pop_check(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      fail_now({tag, "_sb_empty"});
      return;
    end
    x = sb.pop_front();
    check({tag, "_err"}, rsp_err, x.err);
    if (x.chk_data) check({tag, "_rdata"}, rsp_rdata, x.rdata);
  endtask

  // ---------------------------------------------------------- slave model
  int            cfg_aw_lat = 0, cfg_w_lat = 0, cfg_ar_lat = 0;
  logic [1:0]    cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  bit            cfg_r_stall = 1'b0;
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] mtime = '0;
  int            aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  bit            aw_fire = 0, w_fire = 0, ar_fire = 0, b_fire = 0, r_fire = 0;
  bit            got_aw = 0, got_w = 0, got_ar = 0;
  logic [AW-1:0] cap_awaddr = '0, cap_araddr = '0;
  logic [DW-1:0] cap_wdata = '0;
  logic [3:0]    cap_wstrb = '0;
  int            aw_high = 0, w_high = 0, ar_high = 0, b_beats = 0, prot_err = 0;

  // Slave acts on falling edges; a handshake set up at one falling edge is
  // taken by the DUT on the following rising edge and retired here next time.
  initial begin
    logic [DW-1:0] v;
    M_AXI_awready = 1'b0; M_AXI_wready = 1'b0; M_AXI_arready = 1'b0;
    M_AXI_bvalid = 1'b0; M_AXI_bresp = 2'b00;
    M_AXI_rvalid = 1'b0; M_AXI_rresp = 2'b00; M_AXI_rdata = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        M_AXI_awready = 1'b0; M_AXI_wready = 1'b0; M_AXI_arready = 1'b0;
        M_AXI_bvalid = 1'b0; M_AXI_rvalid = 1'b0;
        aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
        got_aw = 0; got_w = 0; got_ar = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      end else begin
        mtime = mtime + 1;
        if (aw_fire) got_aw = 1;
        if (w_fire) got_w = 1;
        if (ar_fire) got_ar = 1;
        if (b_fire) begin M_AXI_bvalid = 1'b0; b_beats++; end
        if (r_fire) M_AXI_rvalid = 1'b0;
        if (got_aw && got_w && !M_AXI_bvalid) begin
          v = mem.exists(cap_awaddr) ? mem[cap_awaddr] : '0;
          for (int i = 0; i < 4; i++) if (cap_wstrb[i]) v[8*i +: 8] = cap_wdata[8*i +: 8];
          mem[cap_awaddr] = v;
          M_AXI_bvalid = 1'b1; M_AXI_bresp = cfg_bresp;
          got_aw = 0; got_w = 0;
        end
        if (got_ar && !M_AXI_rvalid && !cfg_r_stall) begin
          if (cap_araddr == 16'hBFF8) M_AXI_rdata = mtime;
          else M_AXI_rdata = mem.exists(cap_araddr) ? mem[cap_araddr] : '0;
          M_AXI_rresp = cfg_rresp; M_AXI_rvalid = 1'b1; got_ar = 0;
        end
        // protocol rules observed on the master side
        if (M_AXI_bready && (M_AXI_awvalid || M_AXI_wvalid)) prot_err++;
        if (M_AXI_rready && M_AXI_arvalid) prot_err++;
        if (M_AXI_awprot != 3'b000 || M_AXI_arprot != 3'b000) prot_err++;
        if (M_AXI_awvalid) begin
          if (aw_cnt > 0 && M_AXI_awaddr !== cap_awaddr) prot_err++;
          cap_awaddr = M_AXI_awaddr; M_AXI_awready = (aw_cnt >= cfg_aw_lat);
          aw_cnt++; aw_high++;
        end else begin aw_cnt = 0; M_AXI_awready = 1'b0; end
        if (M_AXI_wvalid) begin
          if (w_cnt > 0 && (M_AXI_wdata !== cap_wdata || M_AXI_wstrb !== cap_wstrb)) prot_err++;
          cap_wdata = M_AXI_wdata; cap_wstrb = M_AXI_wstrb;
          M_AXI_wready = (w_cnt >= cfg_w_lat); w_cnt++; w_high++;
        end else begin w_cnt = 0; M_AXI_wready = 1'b0; end
        if (M_AXI_arvalid) begin
          if (ar_cnt > 0 && M_AXI_araddr !== cap_araddr) prot_err++;
          cap_araddr = M_AXI_araddr; M_AXI_arready = (ar_cnt >= cfg_ar_lat);
          ar_cnt++; ar_high++;
        end else begin ar_cnt = 0; M_AXI_arready = 1'b0; end
        aw_fire = M_AXI_awvalid && M_AXI_awready;
        w_fire  = M_AXI_wvalid && M_AXI_wready;
        ar_fire = M_AXI_arvalid && M_AXI_arready;
        b_fire  = M_AXI_bvalid && M_AXI_bready;
        r_fire  = M_AXI_rvalid && M_AXI_rready;
      end
    end
  end

  // --------------------------------------------------------- request driver
  // Called on a falling edge with the bridge idle.
  task automatic do_req(input string tag, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [3:0] wstrb,
                        input int awl, input int wl, input int arl, input logic [1:0] resp,
                        input logic [DW-1:0] exp_rdata, input logic exp_err,
                        input bit chk_data, input int hold, output logic [DW-1:0] got);
    int n, lat, b0, awh0, wh0, arh0, pe0, exp_lat;
    bit stable_bad;
    logic [DW-1:0] r0;
    logic e0;
    exp_t x;
    got = '0;
    cfg_aw_lat = awl; cfg_w_lat = wl; cfg_ar_lat = arl;
    cfg_bresp = resp; cfg_rresp = resp;
    b0 = b_beats; awh0 = aw_high; wh0 = w_high; arh0 = ar_high; pe0 = prot_err;
    x.rdata = exp_rdata; x.err = exp_err; x.chk_data = chk_data;
    sb.push_back(x);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge aclk); n++; end
    if (!req_ready) begin
      fail_now({tag, "_accept"}); req_valid = 1'b0; sb.delete(); return;
    end
    @(negedge aclk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge aclk); lat++; end
    if (!rsp_valid) begin fail_now({tag, "_rsp"}); sb.delete(); return; end
    exp_lat = 3 + (we ? ((awl > wl) ? awl : wl) : arl);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_req_ready_in_rsp"}, req_ready, 1'b0);
    r0 = rsp_rdata; e0 = rsp_err; stable_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== r0 || rsp_err !== e0 || req_ready !== 1'b0)
        stable_bad = 1'b1;
    end
    if (hold > 0) check({tag, "_rsp_stable"}, stable_bad, 1'b0);
    got = rsp_rdata;
    pop_check(tag);
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    check({tag, "_rsp_done"}, {rsp_valid, req_ready}, 2'b01);
    if (we) begin
      check({tag, "_awaddr"}, cap_awaddr, addr);
      check({tag, "_wdata"}, {cap_wstrb, cap_wdata}, {wstrb, wdata});
      check({tag, "_aw_cycles"}, aw_high - awh0, awl + 1);
      check({tag, "_w_cycles"}, w_high - wh0, wl + 1);
      check({tag, "_b_beats"}, b_beats - b0, 1);
    end else begin
      check({tag, "_araddr"}, cap_araddr, addr);
      check({tag, "_ar_cycles"}, ar_high - arh0, arl + 1);
      check({tag, "_b_beats"}, b_beats - b0, 0);
    end
    check({tag, "_protocol"}, prot_err - pe0, 0);
  endtask

  // ----------------------------------------------------------- vector table
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    int            aw_lat, w_lat, ar_lat;
    logic [1:0]    resp;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  initial begin
    vec_t vt[12];
    logic [DW-1:0] got, t1, t2;
    int n;
    bit seen;

    vt[0]  = '{1'b1, 16'h0000, 32'h0000_0001, 4'hF, 0, 0, 0, 2'b00, 32'h0, 1'b0};
    vt[1]  = '{1'b1, 16'h4000, 32'h0000_0010, 4'hF, 0, 0, 0, 2'b00, 32'h0, 1'b0};
    vt[2]  = '{1'b1, 16'h4004, 32'h0000_0000, 4'hF, 1, 1, 0, 2'b00, 32'h0, 1'b0};
    vt[3]  = '{1'b0, 16'h0000, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'h0000_0001, 1'b0};
    vt[4]  = '{1'b1, 16'h0100, 32'h1122_3344, 4'hF, 3, 0, 0, 2'b00, 32'h0, 1'b0};
    vt[5]  = '{1'b1, 16'h0100, 32'hAABB_CCDD, 4'h5, 0, 3, 0, 2'b00, 32'h0, 1'b0};
    vt[6]  = '{1'b0, 16'h0100, 32'h0,         4'h0, 0, 0, 2, 2'b00, 32'h11BB_33DD, 1'b0};
    vt[7]  = '{1'b1, 16'h0200, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b11, 32'h0, 1'b1};
    vt[8]  = '{1'b0, 16'h0200, 32'h0,         4'h0, 0, 0, 0, 2'b10, 32'hDEAD_BEEF, 1'b1};
    vt[9]  = '{1'b0, 16'h0300, 32'h0,         4'h0, 0, 0, 0, 2'b01, 32'h0, 1'b0};
    vt[10] = '{1'b1, 16'h0100, 32'hFFFF_FFFF, 4'h0, 2, 2, 0, 2'b00, 32'h0, 1'b0};
    vt[11] = '{1'b0, 16'h0100, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'h11BB_33DD, 1'b0};

    // reset state
    repeat (3) @(negedge aclk);
    check("rst_req", {req_ready, rsp_valid, rsp_err}, 3'b100);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_axi_valid_ready",
          {M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, M_AXI_arvalid, M_AXI_rready}, 5'b0);
    check("rst_latched", {M_AXI_awaddr, M_AXI_wdata, M_AXI_wstrb}, 52'h0);
    aresetn = 1'b1;
    @(negedge aclk);

    for (int i = 0; i < 12; i++)
      do_req($sformatf("v%0d", i), vt[i].we, vt[i].addr, vt[i].wdata, vt[i].wstrb,
             vt[i].aw_lat, vt[i].w_lat, vt[i].ar_lat, vt[i].resp,
             vt[i].exp_rdata, vt[i].exp_err, 1'b1, (i == 8) ? 5 : 0, got);

    // mtime polling: successive reads must advance
    do_req("mtime0", 1'b0, 16'hBFF8, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h0, 1'b0, 1'b0, 0, t1);
    do_req("mtime1", 1'b0, 16'hBFF8, 32'h0, 4'h0, 0, 0, 1, 2'b00, 32'h0, 1'b0, 1'b0, 0, t2);
    check("mtime_increments", (t2 > t1), 1'b1);

    // back-to-back write then read with req_valid held high
    cfg_aw_lat = 0; cfg_w_lat = 0; cfg_ar_lat = 0; cfg_bresp = 2'b00; cfg_rresp = 2'b00;
    sb.push_back('{32'h0, 1'b0, 1'b1});
    sb.push_back('{32'hCAFE_0001, 1'b0, 1'b1});
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0400; req_wdata = 32'hCAFE_0001; req_wstrb = 4'hF;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge aclk); n++; end
    @(negedge aclk);
    req_we = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge aclk); n++; end
    if (!rsp_valid) fail_now("b2b_wr_rsp");
    check("b2b_ready_low_in_rsp", req_ready, 1'b0);
    pop_check("b2b_wr");
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    check("b2b_ready_next_cycle", {req_ready, rsp_valid}, 2'b10);
    @(negedge aclk);
    req_valid = 1'b0;
    check("b2b_second_accepted", req_ready, 1'b0);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge aclk); n++; end
    if (!rsp_valid) fail_now("b2b_rd_rsp");
    pop_check("b2b_rd");
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;

    // asynchronous reset while waiting in RDATA
    cfg_r_stall = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0100;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge aclk); n++; end
    @(negedge aclk);
    req_valid = 1'b0;
    n = 0;
    while (!M_AXI_rready && n < 100) begin @(negedge aclk); n++; end
    if (!M_AXI_rready) fail_now("rst_mid_rready");
    @(posedge aclk);
    #2 aresetn = 1'b0;
    #1 check("rst_mid_async", {M_AXI_rready, M_AXI_arvalid, rsp_valid, req_ready}, 4'b0001);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    cfg_r_stall = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge aclk); if (rsp_valid) seen = 1'b1; end
    check("rst_mid_no_rsp", seen, 1'b0);
    do_req("post_rst", 1'b0, 16'h0100, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h11BB_33DD, 1'b0, 1'b1, 0, got);

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
